// File: rtl/binaddsub_seq.sv
// Digit-serial adder/subtractor: one DIGIT-bit ripple slice per clock.
// Subtraction folds into the add path as a + ~b + 1.
module binaddsub_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]       opa, opb, acc, acc_n;
  logic                   carry;
  logic [CW-1:0]          cnt;
  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] cat;
  logic                   msb_cin;
  logic                   last;
  logic                   accept;

  always_comb begin
    dsum = {1'b0, opa[DIGIT-1:0]}
         + {1'b0, opb[DIGIT-1:0]}
         + {{DIGIT{1'b0}}, carry};
    // carry into the slice MSB, recovered from its sum bit
    msb_cin = dsum[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
    cat     = {dsum[DIGIT-1:0], acc};
    acc_n   = cat[WIDTH+DIGIT-1:DIGIT];
    last    = (cnt == CW'(N - 1));
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (last) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        opa   <= a;
        opb   <= b ^ {WIDTH{mode}};
        carry <= mode;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        opa   <= opa >> DIGIT;
        opb   <= opb >> DIGIT;
        carry <= dsum[DIGIT];
        acc   <= acc_n;
        cnt   <= cnt + 1'b1;
        if (last) begin
          s    <= acc_n;
          cout <= dsum[DIGIT];
          ovf  <= msb_cin ^ dsum[DIGIT];
          zero <= (acc_n == '0);
          done <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_binaddsub_seq.sv
// Bench for binaddsub_seq: 4-bit corner table, handshake sequences,
// and an 8-bit sweep over all DIGIT choices against a reference model.
module tb_binaddsub_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
  } sb_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [3:0] s;
    logic       c;
    logic       o;
    logic       z;
  } vec_t;

  logic       st4 = 1'b0;
  logic       md4 = 1'b0;
  logic [3:0] a4  = '0;
  logic [3:0] b4  = '0;
  logic [3:0] s4;
  logic       busy4, done4, c4, o4, z4;

  binaddsub_seq #(.WIDTH(4), .DIGIT(1)) u4 (
    .clk(clk), .rst(rst), .start(st4), .mode(md4),
    .a(a4), .b(b4), .busy(busy4), .done(done4),
    .s(s4), .cout(c4), .ovf(o4), .zero(z4)
  );

  logic       st8[4];
  logic       md8[4];
  logic [7:0] a8[4];
  logic [7:0] b8[4];
  logic [7:0] s8[4];
  logic       busy8[4], done8[4], c8[4], o8[4], z8[4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g
      binaddsub_seq #(.WIDTH(8), .DIGIT(1 << gi)) u (
        .clk(clk), .rst(rst), .start(st8[gi]), .mode(md8[gi]),
        .a(a8[gi]), .b(b8[gi]), .busy(busy8[gi]), .done(done8[gi]),
        .s(s8[gi]), .cout(c8[gi]), .ovf(o8[gi]), .zero(z8[gi])
      );
    end
  endgenerate

  res_t e4;
  res_t last4;
  sb_t  q4[$];
  sb_t  q8[$];
  int   dn4 = 0;
  int   ovl = 0;

  function automatic res_t model(int w, logic [7:0] a, logic [7:0] b,
                                 logic m);
    res_t       r;
    logic [7:0] msk, bb;
    logic [8:0] sum;
    msk = 8'((9'd1 << w) - 9'd1);
    bb  = (m ? ~b : b) & msk;
    sum = {1'b0, a & msk} + {1'b0, bb} + {8'd0, m};
    r.s = sum[7:0] & msk;
    r.c = sum[w];
    r.o = (a[w-1] == bb[w-1]) && (r.s[w-1] != a[w-1]);
    r.z = (r.s == 8'd0);
    return r;
  endfunction

  function automatic res_t mk(logic [7:0] s, logic c, logic o, logic z);
    res_t r;
    r.s = s;
    r.c = c;
    r.o = o;
    r.z = z;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // one cycle of the 4-bit DUT: record acceptance, then score outputs
  task automatic tick4();
    bit  rn, an;
    sb_t e;
    rn = rst;
    an = st4 && !busy4 && !rst;
    if (an) q4.push_back('{r: e4, acc: cyc + 1});
    @(negedge clk);
    if (rn) begin
      q4.delete();
      last4 = mk(8'd0, 1'b0, 1'b0, 1'b0);
    end
    if (busy4 && done4) ovl++;
    if (done4) begin
      dn4++;
      if (q4.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL spurious_done4: got done=1 want no done (cycle %0d)",
                 cyc);
      end else begin
        e = q4.pop_front();
        chk("res4", {s4, c4, o4, z4}, {e.r.s[3:0], e.r.c, e.r.o, e.r.z});
        chk("lat4", cyc - e.acc, 4);
        last4 = e.r;
      end
    end else if (busy4) begin
      chk("hold4", {s4, c4, o4, z4},
          {last4.s[3:0], last4.c, last4.o, last4.z});
    end
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while ((q4.size() != 0 || busy4) && n < 50) begin
      tick4();
      n++;
    end
    chk("drain4", {31'd0, (q4.size() != 0 || busy4)}, 0);
    q4.delete();
  endtask

  task automatic go4(input logic [3:0] av, input logic [3:0] bv,
                     input logic m, input res_t ex);
    a4  = av;
    b4  = bv;
    md4 = m;
    e4  = ex;
    st4 = 1'b1;
    tick4();
    st4 = 1'b0;
    drain4();
  endtask

  initial begin
    vec_t       tv[8];
    int         d0, nn, n;
    logic [7:0] av, bv;
    logic       mv;
    res_t       ex;
    sb_t        e;

    tv[0] = '{4'h1, 4'h3, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0};
    tv[1] = '{4'h5, 4'hB, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0};
    tv[2] = '{4'hD, 4'hB, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0};
    tv[3] = '{4'h3, 4'h3, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1};
    tv[4] = '{4'hF, 4'hD, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0};
    tv[5] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};
    tv[6] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
    tv[7] = '{4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 4; i++) begin
      st8[i] = 1'b0;
      md8[i] = 1'b0;
      a8[i]  = '0;
      b8[i]  = '0;
    end
    last4 = mk(8'd0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset4", {busy4, done4, s4, c4, o4, z4}, 0);
    for (int i = 0; i < 4; i++)
      chk("reset8", {busy8[i], done8[i], s8[i], c8[i], o8[i], z8[i]}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      go4(tv[i].a, tv[i].b, tv[i].m,
          mk({4'd0, tv[i].s}, tv[i].c, tv[i].o, tv[i].z));

    // second start two cycles into a run must be dropped
    a4 = 4'h5; b4 = 4'h3; md4 = 1'b0;
    e4 = model(4, 8'h05, 8'h03, 1'b0);
    st4 = 1'b1;
    tick4();
    st4 = 1'b0;
    tick4();
    a4 = 4'h9; b4 = 4'h6; md4 = 1'b1;
    e4 = model(4, 8'h09, 8'h06, 1'b1);
    st4 = 1'b1;
    tick4();
    st4 = 1'b0;
    drain4();

    // operands wander while a run is in flight
    a4 = 4'hC; b4 = 4'h4; md4 = 1'b1;
    e4 = model(4, 8'h0C, 8'h04, 1'b1);
    st4 = 1'b1;
    tick4();
    st4 = 1'b0;
    repeat (6) begin
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      md4 = 1'($urandom_range(0, 1));
      tick4();
    end
    drain4();

    // start held high: repeated back-to-back operations
    d0 = dn4;
    a4 = 4'hA; b4 = 4'h3; md4 = 1'b1;
    e4 = model(4, 8'h0A, 8'h03, 1'b1);
    st4 = 1'b1;
    repeat (16) tick4();
    st4 = 1'b0;
    drain4();
    chk("held_count", {31'd0, (dn4 - d0) >= 3}, 1);

    // reset at the second compute edge aborts the run
    a4 = 4'h3; b4 = 4'h1; md4 = 1'b1;
    e4 = model(4, 8'h03, 8'h01, 1'b1);
    st4 = 1'b1;
    tick4();
    st4 = 1'b0;
    tick4();
    rst = 1'b1;
    tick4();
    rst = 1'b0;
    chk("rst_mid", {busy4, done4, s4, c4, o4, z4}, 0);
    d0 = dn4;
    repeat (8) tick4();
    chk("rst_nodone", dn4 - d0, 0);
    go4(tv[1].a, tv[1].b, tv[1].m,
        mk({4'd0, tv[1].s}, tv[1].c, tv[1].o, tv[1].z));
    chk("no_overlap4", ovl, 0);

    // 8-bit sweep across every digit width
    for (int d = 0; d < 4; d++) begin
      nn = 8 >> d;
      for (int k = 0; k < 1001; k++) begin
        if (k == 0) begin
          av = 8'h9C; bv = 8'h3A; mv = 1'b1;
          ex = mk(8'h62, 1'b1, 1'b1, 1'b0);
        end else begin
          av = 8'($urandom);
          bv = 8'($urandom);
          mv = 1'($urandom_range(0, 1));
          ex = model(8, av, bv, mv);
        end
        a8[d]  = av;
        b8[d]  = bv;
        md8[d] = mv;
        st8[d] = 1'b1;
        q8.push_back('{r: ex, acc: cyc + 1});
        @(negedge clk);
        st8[d] = 1'b0;
        n = 1;
        while (!done8[d] && n < 20) begin
          if (busy8[d] && done8[d]) ovl++;
          @(negedge clk);
          n++;
        end
        if (busy8[d] && done8[d]) ovl++;
        e = q8.pop_front();
        if (!done8[d]) begin
          checks++;
          errs++;
          $display("FAIL timeout8 digit=%0d: got no done want done", 1 << d);
        end else begin
          chk($sformatf("res8_d%0d", 1 << d),
              {s8[d], c8[d], o8[d], z8[d]}, {e.r.s, e.r.c, e.r.o, e.r.z});
          chk($sformatf("lat8_d%0d", 1 << d), cyc - e.acc, nn);
        end
      end
    end
    chk("no_overlap", ovl, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
